// File: rtl/maze_region_probe_if.sv
// Probe request/result handshake plus the bitmap RAM read port.
// The slave side is the probe engine; the master side is the
// movement logic together with the bitmap RAM.
interface maze_region_probe_if #(
    parameter int ADDR_W = 15
);
    logic              start;
    logic [7:0]        startx;
    logic [6:0]        starty;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_q;
    logic              busy;
    logic              done;
    logic              hit;
    logic [4:0]        hit_count;

    modport master (
        output start, startx, starty, mem_q,
        input  mem_addr, busy, done, hit, hit_count
    );

    modport slave (
        input  start, startx, starty, mem_q,
        output mem_addr, busy, done, hit, hit_count
    );
endinterface

// File: rtl/maze_region_probe.sv
// Scans a SPRITE_W x SPRITE_H window of the 1-bit maze bitmap and counts
// wall pixels. Off-screen pixels are not read and count as walls; their
// forced sample travels down a small pipeline so it lines up with the
// RAM's one-cycle read latency.
module maze_region_probe #(
    parameter int SPRITE_W = 5,
    parameter int SPRITE_H = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int ADDR_W   = 15
) (
    input  logic                clock,
    input  logic                reset,
    maze_region_probe_if.slave  bus
);
    localparam int TOTAL = SPRITE_W * SPRITE_H;
    localparam int IW    = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int JW    = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t            state_r, state_s;
    logic [7:0]        x_r;
    logic [6:0]        y_r;
    logic [IW-1:0]     i_r, off_i_s, nxt_i_s;
    logic [JW-1:0]     j_r, off_j_s, nxt_j_s;
    logic [CW-1:0]     cnt_r;
    logic [7:0]        base_x_s;
    logic [6:0]        base_y_s;
    logic [8:0]        px_s;
    logic [7:0]        py_s;
    logic              pix_oob_s;
    logic [ADDR_W-1:0] pix_addr_s;
    logic              accept_s, issue_s, sample_s;
    logic [4:0]        count_next_s;
    logic              issue_vld_r, issue_oob_r, smp_vld_r, smp_oob_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              busy_r, done_r, hit_r;
    logic [4:0]        hit_count_r;

    // Linear bitmap address of an on-screen pixel.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] px, input logic [7:0] py);
        pixel_addr = ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px);
    endfunction

    // Current pixel coordinates, its off-screen flag/address and the next window offset.
    always_comb begin
        base_x_s = x_r;
        base_y_s = y_r;
        off_i_s  = i_r;
        off_j_s  = j_r;
        if (state_r == IDLE) begin
            base_x_s = bus.startx;
            base_y_s = bus.starty;
            off_i_s  = {IW{1'b0}};
            off_j_s  = {JW{1'b0}};
        end else begin
            base_x_s = x_r;
            base_y_s = y_r;
        end
        px_s = {1'b0, base_x_s} + 9'(off_i_s);
        py_s = {1'b0, base_y_s} + 8'(off_j_s);
        pix_oob_s  = (px_s >= 9'(SCREEN_W)) || (py_s >= 8'(SCREEN_H));
        pix_addr_s = pix_oob_s ? {ADDR_W{1'b0}} : pixel_addr(px_s, py_s);
        if (off_i_s == IW'(SPRITE_W - 1)) begin
            nxt_i_s = {IW{1'b0}};
            nxt_j_s = off_j_s + JW'(1);
        end else begin
            nxt_i_s = off_i_s + IW'(1);
            nxt_j_s = off_j_s;
        end
        sample_s     = smp_oob_r | bus.mem_q;
        count_next_s = hit_count_r + {4'b0000, sample_s};
    end

    // Next-state logic and the per-cycle accept/issue decisions.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        issue_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    issue_s  = 1'b1;
                    state_s  = SCAN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SCAN: begin
                if (cnt_r == CW'(TOTAL)) begin
                    state_s = DRAIN;
                end else begin
                    issue_s = 1'b1;
                    state_s = SCAN;
                end
            end
            DRAIN:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Window latch, scan counters, read address and OOB/valid pipeline.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_r         <= 8'd0;
            y_r         <= 7'd0;
            i_r         <= {IW{1'b0}};
            j_r         <= {JW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            issue_vld_r <= 1'b0;
            issue_oob_r <= 1'b0;
            smp_vld_r   <= 1'b0;
            smp_oob_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                x_r <= bus.startx;
                y_r <= bus.starty;
            end
            if (issue_s) begin
                mem_addr_r <= pix_addr_s;
                i_r        <= nxt_i_s;
                j_r        <= nxt_j_s;
                cnt_r      <= accept_s ? CW'(1) : cnt_r + CW'(1);
            end
            issue_vld_r <= issue_s;
            issue_oob_r <= issue_s & pix_oob_s;
            smp_vld_r   <= issue_vld_r;
            smp_oob_r   <= issue_oob_r;
        end
    end

    // Result accumulation and busy/done status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            hit_r       <= 1'b0;
            hit_count_r <= 5'd0;
        end else begin
            done_r <= (state_r == DRAIN);
            if (accept_s) begin
                busy_r      <= 1'b1;
                hit_r       <= 1'b0;
                hit_count_r <= 5'd0;
            end else begin
                if (smp_vld_r) begin
                    hit_count_r <= count_next_s;
                end
                if (state_r == DRAIN) begin
                    busy_r <= 1'b0;
                    hit_r  <= (count_next_s != 5'd0);
                end
            end
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.hit       = hit_r;
    assign bus.hit_count = hit_count_r;
endmodule
